// File: rtl/dp_accumulator_pkg.sv
// Shared types and constants for the dot-product accumulator slice.
package mannix_dp_pkg;

    localparam int unsigned PROD_W_DEF = 17;
    localparam int unsigned ACC_W_DEF  = 32;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } dp_acc_state_t;

endpackage

// File: rtl/dp_accumulator_if.sv
// Control, product-beat and result handshake bundle of the dot-product accumulator.
interface dp_accumulator_if
    import mannix_dp_pkg::*;
#(
    parameter int unsigned N_LANES = 4,
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned LEN_W   = 16
);

    logic                       start;
    logic [LEN_W-1:0]           cfg_beats;
    logic                       in_valid;
    logic                       in_ready;
    logic [N_LANES*PROD_W-1:0]  in_prod;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [ACC_W-1:0]    out_data;
    logic                       out_sat;
    logic                       busy;

    modport master (
        output start, cfg_beats, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, cfg_beats, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );

endinterface

// File: rtl/dp_accumulator_lane_adder_tree.sv
// Balanced binary adder tree reducing N_LANES signed products to one signed lane sum.
module lane_adder_tree #(
    parameter int unsigned N_LANES = 4,
    parameter int unsigned PROD_W  = 17,
    parameter int unsigned LVL     = $clog2(N_LANES),
    parameter int unsigned SUM_W   = PROD_W + LVL
) (
    input  logic [N_LANES*PROD_W-1:0] prod,
    output logic signed [SUM_W-1:0]   sum
);

    // Level 0 holds the sign-extended leaves; each further level halves the node count.
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        logic signed [SUM_W-1:0] v [N_LANES >> l];
        for (genvar j = 0; j < (N_LANES >> l); j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign v[j] = SUM_W'(signed'(prod[j*PROD_W +: PROD_W]));
            end else begin : g_add
                assign v[j] = g_lvl[l-1].v[2*j] + g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LVL].v[0];

endmodule

// File: rtl/dp_accumulator.sv
// Accumulates adder-tree lane sums over a configured beat count and emits one saturated result.
module dp_accumulator
    import mannix_dp_pkg::*;
#(
    parameter int unsigned N_LANES = 4,
    parameter int unsigned PROD_W  = PROD_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned LEN_W   = 16
) (
    input  logic           clk,
    input  logic           rst,
    dp_accumulator_if.slave bus
);

    localparam int unsigned LVL   = $clog2(N_LANES);
    localparam int unsigned SUM_W = PROD_W + LVL;

    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    dp_acc_state_t           state, state_n;
    logic [LEN_W-1:0]        beats, beats_n;
    logic [LEN_W-1:0]        cnt, cnt_n;
    logic signed [ACC_W-1:0] acc, acc_n;
    logic                    sat, sat_n;
    logic signed [ACC_W-1:0] odata_n;
    logic                    osat_n;

    logic signed [SUM_W-1:0] lane_sum;
    logic signed [ACC_W:0]   raw_sum;
    logic signed [ACC_W-1:0] sum_clamped;
    logic                    sum_ovf;
    logic                    fire;
    logic                    last_beat;

    lane_adder_tree #(
        .N_LANES (N_LANES),
        .PROD_W  (PROD_W),
        .LVL     (LVL),
        .SUM_W   (SUM_W)
    ) u_tree (
        .prod (bus.in_prod),
        .sum  (lane_sum)
    );

    // One guard bit above ACC_W is enough: a lane sum is far smaller than the accumulator range.
    always_comb begin
        raw_sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(lane_sum);
        sum_ovf     = 1'b0;
        sum_clamped = ACC_W'(raw_sum);
        if (raw_sum > SAT_MAX) begin
            sum_clamped = ACC_W'(SAT_MAX);
            sum_ovf     = 1'b1;
        end else if (raw_sum < SAT_MIN) begin
            sum_clamped = ACC_W'(SAT_MIN);
            sum_ovf     = 1'b1;
        end
    end

    assign fire      = (state == ACC) && bus.in_ready && bus.in_valid;
    assign last_beat = (cnt == beats - LEN_W'(1));

    // Next-state and next-datapath decode.
    always_comb begin
        state_n = state;
        beats_n = beats;
        cnt_n   = cnt;
        acc_n   = acc;
        sat_n   = sat;
        odata_n = bus.out_data;
        osat_n  = bus.out_sat;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    beats_n = bus.cfg_beats;
                    cnt_n   = '0;
                    acc_n   = '0;
                    sat_n   = 1'b0;
                    if (bus.cfg_beats == '0) begin
                        state_n = OUT;
                        odata_n = '0;
                        osat_n  = 1'b0;
                    end else begin
                        state_n = ACC;
                    end
                end
            end
            ACC: begin
                if (fire) begin
                    acc_n = sum_clamped;
                    sat_n = sat | sum_ovf;
                    cnt_n = cnt + LEN_W'(1);
                    if (last_beat) begin
                        state_n = OUT;
                        odata_n = sum_clamped;
                        osat_n  = sat | sum_ovf;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are decoded from the next state so they are plain flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beats         <= '0;
            cnt           <= '0;
            acc           <= '0;
            sat           <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_n;
            beats         <= beats_n;
            cnt           <= cnt_n;
            acc           <= acc_n;
            sat           <= sat_n;
            bus.in_ready  <= (state_n == ACC);
            bus.out_valid <= (state_n == OUT);
            bus.out_data  <= odata_n;
            bus.out_sat   <= osat_n;
            bus.busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_dp_accumulator.sv
// Directed bench for dp_accumulator: vector table plus reset, zero-length and narrow-saturation sequences.
module tb_dp_accumulator;
    import mannix_dp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dp_accumulator_if #(.N_LANES(4), .PROD_W(17), .ACC_W(32), .LEN_W(16)) bus ();
    dp_accumulator_if #(.N_LANES(4), .PROD_W(17), .ACC_W(20), .LEN_W(16)) bus20 ();

    dp_accumulator #(.N_LANES(4), .PROD_W(17), .ACC_W(32), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dp_accumulator #(.N_LANES(4), .PROD_W(17), .ACC_W(20), .LEN_W(16)) dut20 (
        .clk (clk),
        .rst (rst),
        .bus (bus20)
    );

    typedef struct {
        int     n;
        int     p [3][4];
        longint exp;
        bit     exp_sat;
        bit     gaps;
        int     hold;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cur_pat [3][4];
    vec_t vecs [6];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int b);
        for (int i = 0; i < 4; i++) bus.in_prod[i*17 +: 17] = 17'(cur_pat[b % 3][i]);
    endtask

    // Full operation on the 32-bit instance; beat b uses pattern b%3 from cur_pat.
    task automatic do_op(input int n, input bit gaps, input int hold, input longint exp,
                         input bit exp_sat);
        int  taken;
        int  cyc;
        bit  take;
        bus.start     = 1'b1;
        bus.cfg_beats = 16'(n);
        step();
        bus.start = 1'b0;
        chk("acc_busy", bus.busy, 1);
        taken = 0;
        cyc   = 0;
        while (taken < n && cyc < 2 * n + 20) begin
            bus.in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
            set_lanes(taken);
            if (gaps && cyc == 1) begin
                bus.start     = 1'b1;
                bus.cfg_beats = 16'd1;
            end
            chk("acc_in_ready", bus.in_ready, 1);
            chk("acc_no_out_valid", bus.out_valid, 0);
            take = bus.in_valid && bus.in_ready;
            step();
            bus.start = 1'b0;
            if (take) taken++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("beats_taken", taken, n);
        chk("out_valid_latency", bus.out_valid, 1);
        chk("out_in_ready_low", bus.in_ready, 0);
        chk("out_data", bus.out_data, exp);
        chk("out_sat", bus.out_sat, exp_sat);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.start    = (h == 0);
            step();
            bus.start = 1'b0;
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_out_data", bus.out_data, exp);
            chk("hold_out_sat", bus.out_sat, exp_sat);
            chk("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("post_hs_out_valid", bus.out_valid, 0);
        chk("post_hs_busy", bus.busy, 0);
    endtask

    // Constant-lane operation of 20 beats on the 20-bit instance.
    task automatic run20(input int v, input longint exp);
        int taken;
        int cyc;
        bit take;
        for (int i = 0; i < 4; i++) bus20.in_prod[i*17 +: 17] = 17'(v);
        bus20.start     = 1'b1;
        bus20.cfg_beats = 16'd20;
        step();
        bus20.start    = 1'b0;
        bus20.in_valid = 1'b1;
        taken = 0;
        cyc   = 0;
        while (taken < 20 && cyc < 60) begin
            take = bus20.in_valid && bus20.in_ready;
            step();
            if (take) taken++;
            cyc++;
        end
        bus20.in_valid = 1'b0;
        chk("sat20_beats", taken, 20);
        chk("sat20_out_valid", bus20.out_valid, 1);
        chk("sat20_out_data", bus20.out_data, exp);
        chk("sat20_out_sat", bus20.out_sat, 1);
        bus20.out_ready = 1'b1;
        step();
        bus20.out_ready = 1'b0;
        chk("sat20_post_valid", bus20.out_valid, 0);
        chk("sat20_post_busy", bus20.busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, '{'{1, 2, 3, 4}, '{-1, -1, -1, -1}, '{100, 0, 0, -50}}, 56, 1'b0, 1'b0, 0};
        vecs[1] = '{1, '{'{16384, 16384, 16384, 16384}, '{0, 0, 0, 0}, '{0, 0, 0, 0}}, 65536, 1'b0, 1'b0, 0};
        vecs[2] = '{1, '{'{-16384, -16384, -16384, -16384}, '{0, 0, 0, 0}, '{0, 0, 0, 0}}, -65536, 1'b0, 1'b0, 0};
        vecs[3] = '{5, '{'{1, 1, 1, 1}, '{-10, 20, -30, 40}, '{65535, -65536, 0, 0}}, 47, 1'b0, 1'b1, 5};
        vecs[4] = '{8200, '{'{65535, 65535, 65535, 65535}, '{65535, 65535, 65535, 65535},
                            '{65535, 65535, 65535, 65535}}, longint'(ACC_MAX), 1'b1, 1'b0, 0};
        vecs[5] = '{8193, '{'{-65536, -65536, -65536, -65536}, '{-65536, -65536, -65536, -65536},
                            '{-65536, -65536, -65536, -65536}}, longint'(ACC_MIN), 1'b1, 1'b0, 0};

        bus.start = 1'b0;   bus.cfg_beats = '0;   bus.in_valid = 1'b0;
        bus.in_prod = '0;   bus.out_ready = 1'b0;
        bus20.start = 1'b0; bus20.cfg_beats = '0; bus20.in_valid = 1'b0;
        bus20.in_prod = '0; bus20.out_ready = 1'b0;

        rst = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            cur_pat = vecs[i].p;
            do_op(vecs[i].n, vecs[i].gaps, vecs[i].hold, vecs[i].exp, vecs[i].exp_sat);
            step();
        end

        // Zero length straight after a saturated run: sat must not carry over.
        bus.start     = 1'b1;
        bus.cfg_beats = 16'd0;
        step();
        bus.start = 1'b0;
        chk("zero_out_valid", bus.out_valid, 1);
        chk("zero_out_data", bus.out_data, 0);
        chk("zero_out_sat", bus.out_sat, 0);
        chk("zero_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("zero_post_valid", bus.out_valid, 0);
        chk("zero_post_in_ready", bus.in_ready, 0);
        step();

        // Abort after two of four beats, then verify a fresh run carries no residue.
        for (int b = 0; b < 3; b++) cur_pat[b] = '{1000, 1000, 1000, 1000};
        bus.start     = 1'b1;
        bus.cfg_beats = 16'd4;
        step();
        bus.start = 1'b0;
        set_lanes(0);
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        step();
        for (int b = 0; b < 3; b++) cur_pat[b] = '{5, 5, 5, 5};
        do_op(1, 1'b0, 0, 20, 1'b0);

        run20(16129, 524287);
        step();
        run20(-16129, -524288);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_accumulator.md
Name: dp_accumulator

Overview:
- Downstream consumer of the dot_product multiplier array.
- Each beat takes N_LANES signed 17-bit products, reduces them with an adder tree, and accumulates over a configured number of beats.
- Produces one saturated signed dot-product result per operation on a valid/ready output.
- Sits between the multiplier lanes and the requantization/activation stage of the convolution/FC datapath.

Parameters:
- N_LANES, 4, number of product lanes per beat; power of two, ≥1.
- PROD_W, 17, width of each signed product input.
- ACC_W, 32, width of the signed accumulator and result.
- LEN_W, 16, width of the beat-count configuration.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin an operation; honoured only in IDLE.
- cfg_beats  in  LEN_W  unsigned number of beats to accumulate; sampled when start is honoured.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a beat.
- in_prod  in  N_LANES*PROD_W  packed signed products; lane i at bits [i*PROD_W +: PROD_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  ACC_W  signed accumulated result.
- out_sat  out  1  set if any saturation occurred during the operation.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - State goes to IDLE.
  - in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0.
  - Accumulator and beat counter are cleared.
  - Reset overrides everything and aborts any in-flight operation without producing a result.
- States: IDLE, ACC, OUT.
- IDLE:
  - On start=1, latch cfg_beats, clear the accumulator, beat counter and sat flag.
  - If cfg_beats==0, go to OUT with out_data=0, out_sat=0.
  - Otherwise go to ACC.
  - in_valid is ignored in IDLE.
- ACC:
  - in_ready=1 (registered state decode, no combinational path from in_valid).
  - A beat is accepted when in_valid && in_ready.
  - Lane sum is computed combinationally at width PROD_W+log2(N_LANES) (19 bits default), sign-extended to ACC_W+1, and added to the accumulator.
  - If the result exceeds the ACC_W signed range, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set the sat flag.
  - Beat counter increments per accepted beat.
  - On accepting beat number cfg_beats-1, register the saturated sum into out_data and the sat flag into out_sat, then go to OUT.
  - Latency: out_valid=1 in the cycle after the last beat handshake.
  - No beat is accepted in that cycle (in_ready=0 in OUT).
- OUT:
  - out_valid=1; out_data and out_sat stay stable until out_valid && out_ready.
  - On handshake, go to IDLE; out_valid=0 next cycle.
  - out_data retains its last value after the handshake; it is meaningful only while out_valid=1.
- start while busy (ACC or OUT) is ignored; the latched cfg_beats is unchanged.
- Back-to-back operations: minimum one IDLE cycle between operations. Throughput is cfg_beats+2 cycles per result with out_ready tied high.
- in_valid gaps in ACC stall accumulation with no state change.
- cfg_beats=2^LEN_W-1 is supported; the counter must not wrap before completion.

Decomposition:
- Package mannix_dp_pkg:
  - ACC_W/PROD_W defaults.
  - typedef enum logic [1:0] {IDLE, ACC, OUT} dp_acc_state_t.
  - Saturation-limit constants ACC_MAX and ACC_MIN.
- Sub-module lane_adder_tree: purely combinational signed reduction of N_LANES×PROD_W to PROD_W+$clog2(N_LANES) bits, built as a balanced binary tree.

Test Plan:
1. Basic sum:
   - Stimulus: N_LANES=4, start with cfg_beats=3; beats {1,2,3,4}, {-1,-1,-1,-1}, {100,0,0,-50}.
   - Required: out_valid one cycle after the 3rd handshake; out_data=56, out_sat=0.
2. Extreme products:
   - Stimulus: cfg_beats=1, all lanes 16384 (127×127=16129 plus margin; max legal 17-bit +65535).
   - Required: out_data=65536.
   - Repeat with all lanes -16384 → out_data=-65536.
3. Saturation:
   - Stimulus: ACC_W=20, cfg_beats=20, every lane 16129 (sum 64516 per beat).
   - Required: out_data=524287, out_sat=1.
   - Repeat with all lanes -16129 → out_data=-524288, out_sat=1.
4. Backpressure and stalls:
   - Stimulus: in_valid toggling 1/0 each cycle, out_ready held 0 for 5 cycles after out_valid.
   - Required: result is correct and out_data stays stable all 5 cycles.
   - start pulsed during ACC and OUT is ignored.
   - in_ready=0 throughout OUT.
5. Zero length:
   - Stimulus: start with cfg_beats=0.
   - Required: out_valid=1 the next cycle with out_data=0; in_ready never asserts.
6. Reset mid-operation:
   - Stimulus: rst=1 for one cycle after 2 of 4 beats.
   - Required: next cycle IDLE, out_valid=0, busy=0.
   - A new operation with cfg_beats=1 and lanes {5,5,5,5} gives out_data=20, with no residue from the aborted run.
